// File: rtl/stage_mem_pkg.sv
// Shared ISA constants, state encoding and register-write decode helpers for the
// memory stage. Instruction fields live in bits [15:0] of the instruction word.
package stage_mem_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_NOT = 6'd4;
    localparam logic [5:0] FUNC_TCP = 6'd5;
    localparam logic [5:0] FUNC_SHL = 6'd6;
    localparam logic [5:0] FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;
    localparam logic [5:0] FUNC_ENI = 6'd30;
    localparam logic [5:0] FUNC_DSI = 6'd31;

    // BNE r0,r0 can never be taken and writes nothing: a true no-op.
    localparam logic [15:0] INST_NOP = {OP_BNE, 12'h000};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic writes_reg(input logic [3:0] opcode, input logic [5:0] func);
        logic w;
        w = 1'b0;
        case (opcode)
            OP_ADI, OP_ORI, OP_LHI, OP_LWD, OP_JAL: w = 1'b1;
            OP_RTYPE: w = (func <= FUNC_SHR) || (func == FUNC_JRL);
            default:  w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] dest_reg(input logic [3:0] opcode, input logic [5:0] func,
                                            input logic [1:0] rt, input logic [1:0] rd);
        logic [1:0] r;
        r = rt;
        if (opcode == OP_JAL || (opcode == OP_RTYPE && func == FUNC_JRL))
            r = 2'd2;
        else if (opcode == OP_RTYPE)
            r = rd;
        return r;
    endfunction

endpackage

// File: rtl/stage_mem_dmem_handshake.sv
// Data-memory request FSM: captures the request on entry, holds it until d_ack,
// and produces the pipeline stall.
module dmem_handshake
    import stage_mem_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_op_i,
    input  logic                 write_i,
    input  logic [WORD_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic                 d_ack_i,
    output logic                 d_req_o,
    output logic                 d_we_o,
    output logic [WORD_SIZE-1:0] d_address_o,
    output logic [WORD_SIZE-1:0] d_wdata_o,
    output logic                 stall_o,
    output logic                 done_o
);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (mem_op_i) begin
                    state_d = BUSY;
                    addr_d  = addr_i;
                    wdata_d = write_i ? wdata_i : '0;
                    we_d    = write_i;
                end
            end
            BUSY: begin
                if (d_ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == BUSY);
    assign d_req_o     = busy;
    assign d_we_o      = busy & we_q;
    assign d_address_o = busy ? addr_q : '0;
    assign d_wdata_o   = busy ? wdata_q : '0;
    assign done_o      = busy & d_ack_i;
    // Gated by reset_n so stall drops the instant reset asserts.
    assign stall_o     = reset_n & ((~busy & mem_op_i) | (busy & ~d_ack_i));

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: MEM/WB latch around the dmem_handshake request FSM.
// Optional EX forwarding outputs are built when STAGE_MEM_FWD_EN is defined.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_instruction,
    input  logic [WORD_SIZE-1:0] in_aluOut,
    input  logic [WORD_SIZE-1:0] in_storeData,
    output logic                 stall,
    output logic                 d_req,
    output logic                 d_we,
    output logic [WORD_SIZE-1:0] d_address,
    output logic [WORD_SIZE-1:0] d_wdata,
    input  logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 d_ack,
    output logic                 wb_valid,
    output logic [WORD_SIZE-1:0] wb_instruction,
    output logic [WORD_SIZE-1:0] wb_m_data,
`ifdef STAGE_MEM_FWD_EN
    output logic                 fwd_valid,
    output logic [1:0]           fwd_addr,
    output logic [WORD_SIZE-1:0] fwd_data,
`endif
    output logic [WORD_SIZE-1:0] wb_aluOut
);

    logic [3:0]           in_opcode;
    logic                 is_load, is_store, mem_op, mem_done;
    logic                 wb_valid_q, wb_valid_d;
    logic [WORD_SIZE-1:0] wb_instr_q, wb_instr_d;
    logic [WORD_SIZE-1:0] wb_m_data_q, wb_m_data_d;
    logic [WORD_SIZE-1:0] wb_alu_q, wb_alu_d;

    assign in_opcode = in_instruction[15:12];
    assign is_load   = (in_opcode == OP_LWD);
    assign is_store  = (in_opcode == OP_SWD);
    assign mem_op    = in_valid & (is_load | is_store);

    dmem_handshake #(.WORD_SIZE(WORD_SIZE)) u_handshake (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_op_i   (mem_op),
        .write_i    (is_store),
        .addr_i     (in_aluOut),
        .wdata_i    (in_storeData),
        .d_ack_i    (d_ack),
        .d_req_o    (d_req),
        .d_we_o     (d_we),
        .d_address_o(d_address),
        .d_wdata_o  (d_wdata),
        .stall_o    (stall),
        .done_o     (mem_done)
    );

    // Bubbles while stalled so writeback sees each instruction exactly once.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_instr_d  = wb_instr_q;
        wb_m_data_d = wb_m_data_q;
        wb_alu_d    = wb_alu_q;
        if (stall) begin
            wb_valid_d = 1'b0;
            wb_instr_d = WORD_SIZE'(INST_NOP);
        end else begin
            wb_valid_d = in_valid;
            wb_instr_d = in_instruction;
            wb_alu_d   = in_aluOut;
            if (mem_done && is_load)
                wb_m_data_d = d_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q  <= 1'b0;
            wb_instr_q  <= WORD_SIZE'(INST_NOP);
            wb_m_data_q <= '0;
            wb_alu_q    <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_instr_q  <= wb_instr_d;
            wb_m_data_q <= wb_m_data_d;
            wb_alu_q    <= wb_alu_d;
        end
    end

    assign wb_valid       = wb_valid_q;
    assign wb_instruction = wb_instr_q;
    assign wb_m_data      = wb_m_data_q;
    assign wb_aluOut      = wb_alu_q;

`ifdef STAGE_MEM_FWD_EN
    logic [3:0] wb_opcode;
    logic [5:0] wb_func;
    assign wb_opcode = wb_instr_q[15:12];
    assign wb_func   = wb_instr_q[5:0];
    assign fwd_valid = wb_valid_q & writes_reg(wb_opcode, wb_func);
    assign fwd_addr  = dest_reg(wb_opcode, wb_func, wb_instr_q[9:8], wb_instr_q[7:6]);
    assign fwd_data  = (wb_opcode == OP_LWD) ? wb_m_data_q : wb_alu_q;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed scenarios plus randomized traffic
// checked against a transaction-level model of the memory stage.
module tb_stage_mem;
    import stage_mem_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] in_instruction, in_aluOut, in_storeData;
    logic         stall, d_req, d_we, d_ack;
    logic [W-1:0] d_address, d_wdata, d_rdata;
    logic         wb_valid;
    logic [W-1:0] wb_instruction, wb_m_data, wb_aluOut;
`ifdef STAGE_MEM_FWD_EN
    logic         fwd_valid;
    logic [1:0]   fwd_addr;
    logic [W-1:0] fwd_data;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] model_m_data;

    always #5 clk = ~clk;

    stage_mem #(.WORD_SIZE(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_instruction(in_instruction),
        .in_aluOut     (in_aluOut),
        .in_storeData  (in_storeData),
        .stall         (stall),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_ack         (d_ack),
        .wb_valid      (wb_valid),
        .wb_instruction(wb_instruction),
        .wb_m_data     (wb_m_data),
`ifdef STAGE_MEM_FWD_EN
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
`endif
        .wb_aluOut     (wb_aluOut)
    );

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1; in_instruction = {OP_LWD, 12'h000};
        in_aluOut = 16'h0040; in_storeData = 16'h5555;
        d_ack = 1'b0; d_rdata = '0;
        @(negedge clk);
        n_cmp++;
        if ({stall, d_req, d_we, d_address} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got stall/req/we/addr=%h required %h",
                     {stall, d_req, d_we, d_address}, {1'b0, 1'b0, 1'b0, 16'h0000});
        end
        n_cmp++;
        if ({wb_valid, wb_instruction, wb_m_data, wb_aluOut} !== {1'b0, INST_NOP, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_wb: got %h required %h",
                     {wb_valid, wb_instruction, wb_m_data, wb_aluOut}, {1'b0, INST_NOP, 16'h0, 16'h0});
        end
        $display("reset: stall=%0b d_req=%0b wb_valid=%0b", stall, d_req, wb_valid);
        next_cycle();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        model_m_data = '0;
        next_cycle();
    endtask

    task automatic test_non_mem();
        in_valid = 1'b1; in_instruction = {OP_ADI, 2'd0, 2'd1, 8'h05}; in_aluOut = 16'h0005;
        @(negedge clk);
        n_cmp++;
        if ({stall, d_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL adi_stall: got stall/req=%b required 00", {stall, d_req});
        end
        next_cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_aluOut, wb_instruction, d_req} !== {1'b1, 16'h0005, 16'h4105, 1'b0}) begin
            n_fail++;
            $display("FAIL adi_wb: got %h required %h",
                     {wb_valid, wb_aluOut, wb_instruction, d_req}, {1'b1, 16'h0005, 16'h4105, 1'b0});
        end
        $display("adi: wb_valid=%0b wb_aluOut=%h", wb_valid, wb_aluOut);
    endtask

    task automatic test_load();
        int req_cycles = 0;
        int stall_cycles = 0;
        in_valid = 1'b1; in_instruction = {OP_LWD, 2'd0, 2'd2, 8'h00}; in_aluOut = 16'h0040;
        @(negedge clk);
        stall_cycles += int'(stall);
        n_cmp++;
        if ({stall, d_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL lwd_entry: got stall/req=%b required 10", {stall, d_req});
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            d_ack   = (k == 2);
            d_rdata = (k == 2) ? 16'hBEEF : W'($urandom);
            n_cmp++;
            if (wb_valid !== 1'b0 || wb_instruction !== INST_NOP) begin
                n_fail++;
                $display("FAIL lwd_bubble: got valid=%b instr=%h required 0 %h", wb_valid, wb_instruction, INST_NOP);
            end
            @(negedge clk);
            req_cycles   += int'(d_req);
            stall_cycles += int'(stall);
            n_cmp++;
            if ({d_req, d_we, d_address} !== {1'b1, 1'b0, 16'h0040}) begin
                n_fail++;
                $display("FAIL lwd_req: got req/we/addr=%h required %h", {d_req, d_we, d_address}, {1'b1, 1'b0, 16'h0040});
            end
        end
        next_cycle();
        d_ack = 1'b0; in_valid = 1'b0;
        model_m_data = 16'hBEEF;
        n_cmp++;
        if ({wb_valid, wb_m_data, req_cycles, stall_cycles} !== {1'b1, 16'hBEEF, 32'd3, 32'd3}) begin
            n_fail++;
            $display("FAIL lwd_done: got valid=%b m_data=%h req_cyc=%0d stall_cyc=%0d required 1 beef 3 3",
                     wb_valid, wb_m_data, req_cycles, stall_cycles);
        end
        $display("lwd: m_data=%h req_cycles=%0d stall_cycles=%0d", wb_m_data, req_cycles, stall_cycles);
    endtask

    task automatic test_store();
        in_valid = 1'b1; in_instruction = {OP_SWD, 2'd0, 2'd1, 8'h00};
        in_aluOut = 16'h0010; in_storeData = 16'h1234;
        @(negedge clk);
        n_cmp++;
        if ({stall, d_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL swd_entry: got stall/req=%b required 10", {stall, d_req});
        end
        next_cycle();
        d_ack = 1'b1; d_rdata = 16'hDEAD;
        @(negedge clk);
        n_cmp++;
        if ({stall, d_req, d_we, d_address, d_wdata} !== {1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234}) begin
            n_fail++;
            $display("FAIL swd_req: got %h required %h",
                     {stall, d_req, d_we, d_address, d_wdata}, {1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234});
        end
        next_cycle();
        d_ack = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wb_valid, wb_m_data, d_req, d_we, d_address, d_wdata} !== {1'b1, model_m_data, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL swd_done: got %h required %h",
                     {wb_valid, wb_m_data, d_req, d_we, d_address, d_wdata}, {1'b1, model_m_data, 1'b0, 1'b0, 16'h0, 16'h0});
        end
        $display("swd: wb_valid=%0b m_data=%h", wb_valid, wb_m_data);
        next_cycle();
    endtask

    task automatic test_reset_busy();
        in_valid = 1'b1; in_instruction = {OP_LWD, 2'd0, 2'd3, 8'h00}; in_aluOut = 16'h0077;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (d_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstbusy_req: got %b required 1", d_req);
        end
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({d_req, d_we, stall, wb_valid, wb_instruction, wb_m_data} !== {1'b0, 1'b0, 1'b0, 1'b0, INST_NOP, 16'h0}) begin
            n_fail++;
            $display("FAIL rstbusy_async: got %h required %h",
                     {d_req, d_we, stall, wb_valid, wb_instruction, wb_m_data}, {1'b0, 1'b0, 1'b0, 1'b0, INST_NOP, 16'h0});
        end
        next_cycle();
        reset_n = 1'b1;
        model_m_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({d_req, stall} !== 2'b00) begin
                n_fail++;
                $display("FAIL rstbusy_reissue: cycle %0d got req/stall=%b required 00", k, {d_req, stall});
            end
            next_cycle();
        end
        $display("reset_busy: d_req=%0b wb_instruction=%h", d_req, wb_instruction);
    endtask

    task automatic test_random();
        logic [3:0] ops [10] = '{OP_ADI, OP_ORI, OP_LHI, OP_LWD, OP_SWD, OP_RTYPE, OP_JAL, OP_BNE, OP_JMP, OP_LWD};
        for (int t = 0; t < 150; t++) begin
            logic [3:0] op;
            logic       mem, ld;
            int         k;
            op = ops[$urandom_range(0, 9)];
            in_valid       = ($urandom_range(0, 9) < 8);
            in_instruction = {op, 12'(W'($urandom))};
            in_aluOut      = W'($urandom);
            in_storeData   = W'($urandom);
            d_ack          = 1'($urandom);   // stray ack while idle must be ignored
            d_rdata        = W'($urandom);
            ld  = (op == OP_LWD);
            mem = in_valid && (ld || op == OP_SWD);
            k   = $urandom_range(0, 3);
            @(negedge clk);
            n_cmp++;
            if ({stall, d_req, d_address, d_wdata} !== {mem, 1'b0, 16'h0, 16'h0}) begin
                n_fail++;
                $display("FAIL rnd_entry t=%0d: got %h required %h", t, {stall, d_req, d_address, d_wdata}, {mem, 1'b0, 16'h0, 16'h0});
            end
            if (mem) begin
                for (int b = 0; b <= k; b++) begin
                    next_cycle();
                    d_ack   = (b == k);
                    d_rdata = W'($urandom);
                    if (b == k && ld) model_m_data = d_rdata;
                    n_cmp++;
                    if ({wb_valid, wb_instruction} !== {1'b0, INST_NOP}) begin
                        n_fail++;
                        $display("FAIL rnd_bubble t=%0d: got %h required %h", t, {wb_valid, wb_instruction}, {1'b0, INST_NOP});
                    end
                    @(negedge clk);
                    n_cmp++;
                    if ({d_req, d_we, d_address, d_wdata, stall} !== {1'b1, !ld, in_aluOut, ld ? 16'h0 : in_storeData, b != k}) begin
                        n_fail++;
                        $display("FAIL rnd_busy t=%0d b=%0d: got %h required %h", t, b,
                                 {d_req, d_we, d_address, d_wdata, stall}, {1'b1, !ld, in_aluOut, ld ? 16'h0 : in_storeData, b != k});
                    end
                end
            end
            next_cycle();
            d_ack = 1'b0;
            n_cmp++;
            if ({wb_valid, wb_instruction, wb_aluOut, wb_m_data} !== {in_valid, in_instruction, in_aluOut, model_m_data}) begin
                n_fail++;
                $display("FAIL rnd_wb t=%0d: got %h required %h", t,
                         {wb_valid, wb_instruction, wb_aluOut, wb_m_data}, {in_valid, in_instruction, in_aluOut, model_m_data});
            end
            $display("rnd t=%0d op=%0d valid=%0b mem=%0b ack_delay=%0d wb_m_data=%h", t, op, in_valid, mem, k, wb_m_data);
        end
        in_valid = 1'b0;
        next_cycle();
    endtask

`ifdef STAGE_MEM_FWD_EN
    task automatic test_forwarding();
        in_valid = 1'b1; in_instruction = {OP_LWD, 2'd0, 2'd2, 8'h00}; in_aluOut = 16'h0020;
        next_cycle();
        d_ack = 1'b1; d_rdata = 16'h00AA;
        next_cycle();
        d_ack = 1'b0;
        in_instruction = {OP_RTYPE, 2'd2, 2'd0, 2'd0, FUNC_WWD}; in_aluOut = 16'h0101;
        n_cmp++;
        if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 2'd2, 16'h00AA}) begin
            n_fail++;
            $display("FAIL fwd_lwd: got %h required %h", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 2'd2, 16'h00AA});
        end
        next_cycle();
        in_instruction = {OP_ADI, 2'd0, 2'd3, 8'h77}; in_aluOut = 16'h0077;
        n_cmp++;
        if (fwd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_wwd: got %b required 0", fwd_valid);
        end
        next_cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 2'd3, 16'h0077}) begin
            n_fail++;
            $display("FAIL fwd_adi: got %h required %h", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 2'd3, 16'h0077});
        end
        $display("fwd: valid=%0b addr=%0d data=%h", fwd_valid, fwd_addr, fwd_data);
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_non_mem();
        test_load();
        test_store();
        test_reset_busy();
        test_random();
`ifdef STAGE_MEM_FWD_EN
        test_forwarding();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
